// File: rtl/p_fxp_dot_ctrl_pkg.sv
// p_fxp_dot_ctrl_pkg: shared fixed-point format descriptor and dot-product FSM states.
package p_fxp_dot_ctrl_pkg;
    typedef struct packed {
        int   prec;
        int   frac;
        logic sgn;
    } dconf_t;
    localparam dconf_t DEF_DCONF_FXP = '{prec: 16, frac: 8, sgn: 1'b1};
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dot_state_t;
endpackage

// File: rtl/p_fxp_dot_ctrl_mult.sv
// p_fxp_mult: fixed-point multiply, round-half-up to the output format, saturate.
module p_fxp_mult
    import p_fxp_dot_ctrl_pkg::*;
#(
    parameter dconf_t I1_CONF = DEF_DCONF_FXP,
    parameter dconf_t I2_CONF = DEF_DCONF_FXP,
    parameter dconf_t O_CONF  = DEF_DCONF_FXP
) (
    input  logic [I1_CONF.prec-1:0] a,
    input  logic [I2_CONF.prec-1:0] b,
    output logic [O_CONF.prec-1:0]  p,
    output logic                    ovf,
    output logic                    udf,
    output logic                    rounded
);
    localparam int P1 = I1_CONF.prec;
    localparam int P2 = I2_CONF.prec;
    localparam int PO = O_CONF.prec;
    localparam int SH = I1_CONF.frac + I2_CONF.frac - O_CONF.frac;
    localparam int RS = SH > 0 ? SH : 0;
    localparam int LS = SH < 0 ? -SH : 0;
    localparam int PW = (P1 + P2 + 2 + LS > PO + 2) ? P1 + P2 + 2 + LS : PO + 2;
    localparam logic signed [PW-1:0] ONE  = PW'(1);
    localparam logic signed [PW-1:0] BIAS = (ONE << RS) >> 1;
    localparam logic signed [PW-1:0] MASK = (ONE << RS) - ONE;
    localparam logic signed [PW-1:0] MAXV = O_CONF.sgn ? (ONE << (PO - 1)) - ONE : (ONE << PO) - ONE;
    localparam logic signed [PW-1:0] MINV = O_CONF.sgn ? -(ONE << (PO - 1)) : '0;
    logic signed [PW-1:0] ea, eb, prod, scaled;
    always_comb begin
        ea      = I1_CONF.sgn ? PW'($signed(a)) : PW'(a);
        eb      = I2_CONF.sgn ? PW'($signed(b)) : PW'(b);
        prod    = ea * eb;
        scaled  = ((prod + BIAS) >>> RS) <<< LS;
        rounded = |(prod & MASK);
        ovf     = scaled > MAXV || scaled < MINV;
        // udf marks a non-zero exact product that rounds away to zero
        udf     = prod != '0 && scaled == '0;
        p       = scaled > MAXV ? MAXV[PO-1:0] : scaled < MINV ? MINV[PO-1:0] : scaled[PO-1:0];
    end
endmodule

// File: rtl/p_fxp_dot_ctrl.sv
// p_fxp_dot_ctrl: streaming fixed-point dot product with pipelined saturating accumulate.
module p_fxp_dot_ctrl
    import p_fxp_dot_ctrl_pkg::*;
#(
    parameter dconf_t I1_CONF = DEF_DCONF_FXP,
    parameter dconf_t I2_CONF = DEF_DCONF_FXP,
    parameter dconf_t O_CONF  = DEF_DCONF_FXP,
    parameter int     MAX_LEN = 16,
    parameter int     LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [I1_CONF.prec-1:0] in1,
    input  logic [I2_CONF.prec-1:0] in2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [O_CONF.prec-1:0]  out,
    output logic                    ovf,
    output logic                    udf,
    output logic                    rounded,
    output logic                    busy
);
    localparam int PO = O_CONF.prec;
    localparam int AW = PO + 2;
    localparam logic signed [AW-1:0] ONE  = AW'(1);
    localparam logic signed [AW-1:0] AMAX = O_CONF.sgn ? (ONE << (PO - 1)) - ONE : (ONE << PO) - ONE;
    localparam logic signed [AW-1:0] AMIN = O_CONF.sgn ? -(ONE << (PO - 1)) : '0;
    dot_state_t state, state_n;
    logic [LEN_W-1:0] cnt, len_c;
    logic [PO-1:0] acc, acc_n, prod_q, m_p;
    logic [2:0] pf_q, m_f;
    logic pend, accept, clip;
    logic signed [AW-1:0] sum;
    p_fxp_mult #(
        .I1_CONF(I1_CONF),
        .I2_CONF(I2_CONF),
        .O_CONF (O_CONF)
    ) u_mult (
        .a      (in1),
        .b      (in2),
        .p      (m_p),
        .ovf    (m_f[2]),
        .udf    (m_f[1]),
        .rounded(m_f[0])
    );
    assign accept = in_valid && in_ready;
    assign len_c  = len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len;
    assign out    = acc;
    always_comb begin
        sum   = O_CONF.sgn ? AW'($signed(acc)) + AW'($signed(prod_q)) : AW'(acc) + AW'(prod_q);
        clip  = sum > AMAX || sum < AMIN;
        acc_n = sum > AMAX ? AMAX[PO-1:0] : sum < AMIN ? AMIN[PO-1:0] : sum[PO-1:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = len_c == '0 ? DONE : RUN;
            RUN:     if (accept && cnt == LEN_W'(1)) state_n = DRAIN;
            DRAIN:   state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = state == RUN;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end
    // product is registered on accept and folded into the accumulator one edge later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            prod_q  <= '0;
            pf_q    <= '0;
            pend    <= 1'b0;
            cnt     <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            rounded <= 1'b0;
        end else begin
            pend <= accept;
            if (accept) begin
                prod_q <= m_p;
                pf_q   <= m_f;
                cnt    <= cnt - LEN_W'(1);
            end
            if (state == IDLE && start) begin
                acc     <= '0;
                cnt     <= len_c;
                ovf     <= 1'b0;
                udf     <= 1'b0;
                rounded <= 1'b0;
            end else if (pend) begin
                acc     <= acc_n;
                ovf     <= ovf | pf_q[2] | clip;
                udf     <= udf | pf_q[1];
                rounded <= rounded | pf_q[0];
            end
        end
    end
endmodule

// File: tb/tb_p_fxp_dot_ctrl.sv
// tb_p_fxp_dot_ctrl: directed runs against an arithmetic dot-product model (Q8.8 signed).
module tb_p_fxp_dot_ctrl;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [4:0] len = '0;
    logic [15:0] in1 = '0, in2 = '0, out;
    logic in_ready, out_valid, ovf, udf, rounded, busy;
    int checks = 0, errors = 0;
    logic [15:0] pa[$], pb[$];
    logic [15:0] exp_out = '0;
    logic [2:0] exp_f = '0;

    p_fxp_dot_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .ovf      (ovf),
        .udf      (udf),
        .rounded  (rounded),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Real-valued Q8.8 products rounded half-up, then a clamped running sum.
    function automatic void model(input int n);
        longint acc = 0, p, r;
        bit o = 0, u = 0, rd = 0;
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(pa[i])) * longint'($signed(pb[i]));
            r = (p + 128) >>> 8;
            if ((p & 255) != 0) rd = 1;
            if (p != 0 && r == 0) u = 1;
            if (r > 32767) begin r = 32767; o = 1; end
            else if (r < -32768) begin r = -32768; o = 1; end
            acc = acc + r;
            if (acc > 32767) begin acc = 32767; o = 1; end
            else if (acc < -32768) begin acc = -32768; o = 1; end
        end
        exp_out = acc[15:0];
        exp_f   = {o, u, rd};
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("cmp_out", 32'(out), 32'(exp_out));
            chk("cmp_flags", 32'({ovf, udf, rounded}), 32'(exp_f));
        end
    end

    task automatic do_run(input int l, input int gap, input int stall, input bit poke,
                          input logic [15:0] lit_out, input logic [2:0] lit_f);
        int n;
        n = l > 16 ? 16 : l;
        model(n);
        start = 1'b1;
        len = 5'(l);
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", 32'(in_ready), 32'(n > 0));
        chk("start_valid", 32'(out_valid), 32'(n == 0));
        for (int i = 0; i < n; i++) begin
            chk("run_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in1 = pa[i];
            in2 = pb[i];
            if (poke && i == 1) begin
                start = 1'b1;
                len = 5'd1;
            end
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b0;
            if (gap != 0 && i < n - 1) @(negedge clk);
        end
        if (n > 0) begin
            chk("lat_drain", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("lat_done", 32'(out_valid), 32'd1);
        end
        chk("lit_out", 32'(out), 32'(lit_out));
        chk("lit_flags", 32'({ovf, udf, rounded}), 32'(lit_f));
        repeat (stall) @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        start = 1'b1;
        len = 5'd3;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        pa = '{16'h0100, 16'h0200, 16'h0040};
        pb = '{16'h0100, 16'hFF80, 16'h0400};
        do_run(3, 0, 0, 1'b0, 16'h0100, 3'b000);
        pa = '{16'h7F00, 16'h7F00};
        pb = '{16'h0100, 16'h0100};
        do_run(2, 0, 0, 1'b0, 16'h7FFF, 3'b100);
        do_run(0, 0, 2, 1'b0, 16'h0000, 3'b000);
        pa = '{16'h0100, 16'h0200, 16'h0040};
        pb = '{16'h0100, 16'hFF80, 16'h0400};
        do_run(3, 1, 5, 1'b0, 16'h0100, 3'b000);
        pa = '{16'h0001, 16'h0100};
        pb = '{16'h0001, 16'h0080};
        do_run(2, 0, 1, 1'b0, 16'h0080, 3'b011);
        pa = '{16'h8000, 16'h8000};
        pb = '{16'h0100, 16'h0100};
        do_run(2, 0, 0, 1'b0, 16'h8000, 3'b100);
        pa = {};
        pb = {};
        for (int i = 0; i < 16; i++) begin
            pa.push_back(16'h0010);
            pb.push_back(16'h0100);
        end
        do_run(20, 0, 0, 1'b0, 16'h0100, 3'b000);
        pa = '{16'h0100, 16'h0200, 16'h0040};
        pb = '{16'h0100, 16'hFF80, 16'h0400};
        do_run(3, 0, 0, 1'b1, 16'h0100, 3'b000);

        pa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        pb = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        start = 1'b1;
        len = 5'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in1 = pa[0];
        in2 = pb[0];
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out", 32'(out), 32'h0100);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out", 32'(out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        pa = '{16'h0180};
        pb = '{16'h0200};
        do_run(1, 0, 0, 1'b0, 16'h0300, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/p_fxp_dot_ctrl.md
P_FXP_DOT_CTRL -- requirements
Module: p_fxp_dot_ctrl

Interface
REQ-001 SHALL have parameter I1_CONF, default `DEF_DCONF_FXP, giving the format of operand stream 1 (dconf_t).
REQ-002 SHALL have parameter I2_CONF, default `DEF_DCONF_FXP, giving the format of operand stream 2 (dconf_t).
REQ-003 SHALL have parameter O_CONF, default `DEF_DCONF_FXP, giving the format of the product and accumulator (dconf_t).
REQ-004 SHALL have parameter MAX_LEN, default 16, giving the maximum number of terms per dot product.
REQ-005 SHALL have derived parameter LEN_W, default $clog2(MAX_LEN+1), giving the length field width.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  request a new dot product; sampled only in IDLE.
REQ-009 len  input  LEN_W  term count, captured with start; values above MAX_LEN are clamped to MAX_LEN.
REQ-010 in_valid / in_ready  input / output  1 / 1  operand-pair handshake.
REQ-011 in1 / in2  input  I1_CONF.prec / I2_CONF.prec  operand pair.
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out  output  O_CONF.prec  accumulated result.
REQ-014 ovf, udf, rounded  output  1 each  sticky status flags for the current result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE transitions: start with clamped len>0 goes to RUN, clears the accumulator and flags, and loads the remaining-term counter; start with len==0 goes directly to DONE with out=0 and all flags 0.
REQ-018 in_ready SHALL equal (state==RUN); a pair is accepted only on in_valid && in_ready.
REQ-019 Each accepted pair SHALL pass through one internal p_fxp_mult instance (O_CONF output), and the product and its flags SHALL be registered on the accept edge.
REQ-020 The registered product SHALL be added into the accumulator on the edge following its capture, so accumulation is pipelined one cycle behind acceptance.
REQ-021 The counter SHALL decrement per accept; the accept that brings it to 0 moves RUN to DRAIN.
REQ-022 DRAIN SHALL last exactly one cycle (the final accumulate) and then move to DONE.
REQ-023 Latency SHALL be 2 cycles: out_valid is high after the second rising edge following the last accept.
REQ-024 Accumulation SHALL saturate to the O_CONF range: if signed, [-2^(P-1), 2^(P-1)-1]; if unsigned, [0, 2^P-1]; any clip SHALL set ovf.
REQ-025 ovf, udf and rounded SHALL be sticky ORs of the multiplier flags and accumulator saturation since start.
REQ-026 In DONE, out and the flags SHALL be held stable while out_ready is low.
REQ-027 DONE SHALL go to IDLE on out_valid && out_ready; a start in that same cycle is ignored.
REQ-028 start while busy SHALL be ignored, with no effect on the counter or the accumulator.
REQ-029 in_valid outside RUN SHALL be ignored.

Reset
REQ-030 Reset SHALL force state=IDLE, and clear the accumulator, product register, counter and flags to 0.
REQ-031 After reset, in_ready=0, out_valid=0, busy=0 and out=0, and this SHALL hold for reset asserted in any state, including mid-RUN.
REQ-032 A reset mid-operation SHALL abort that operation without producing any output, and the first start after reset SHALL behave normally.

Structure
REQ-033 The state enum typedef dot_state_t SHALL live in the shared perceptron package alongside dconf_t; the saturation bounds SHALL be derived from O_CONF locally.
REQ-034 The only sub-module SHALL be p_fxp_mult; the counter, FSM and saturating adder SHALL be inline.

Verification (16-bit signed, frac 8)
REQ-035 Sum: len=3, pairs (0x0100,0x0100), (0x0200,0xFF80), (0x0040,0x0400) presented back-to-back -> out_valid 2 cycles after the third accept, out=0x0100, all flags 0.
REQ-036 Saturation: len=2, pairs (0x7F00,0x0100) twice -> out=0x7FFF, ovf=1.
REQ-037 Zero length: start with len=0 -> out_valid after 1 edge, out=0x0000, in_ready never asserted.
REQ-038 Backpressure: in_valid toggled every other cycle and out_ready held low 5 cycles -> result unchanged from the unstalled run, and out and flags stable throughout the stall.
REQ-039 Reset mid-RUN: assert reset after the 1st of 4 accepts -> in_ready, out_valid and busy go low immediately; a new len=1 run with (0x0180,0x0200) gives out=0x0300.
REQ-040 start during RUN with a different len -> ignored, and the original term count completes.
